id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with PC+4 and next-PC select; optional skid entry under ID_EX_SKID_BUF_EN.
// Latency: one cycle from decode accept to valid_e. Backpressure: E-side outputs hold while stalled.
// Without skid: ready_d is combinational. With skid: ready_d is registered as "skid entry empty".
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CTRLW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_d,
    output logic             ready_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic [2:0]       funct3_d,
    input  logic [6:0]       op_d,
    input  logic [CTRLW-1:0] ctrl_d,
    output logic             valid_e,
    input  logic             ready_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  imm_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  pcplus4_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [4:0]       rd_e,
    output logic [2:0]       funct3_e,
    output logic [6:0]       op_e,
    output logic [CTRLW-1:0] ctrl_e,
    input  logic             flush_e,
    input  logic             zero_e,
    input  logic             lt_e,
    input  logic             ltu_e,
    output logic [1:0]       pcsrc_e
);

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic [6:0]       op;
        logic [CTRLW-1:0] ctrl;
    } beat_t;

    beat_t in_dat;
    beat_t main_q, main_d;
    logic  vld_q, vld_d;
    logic  accept, consume;

    assign in_dat = '{pc: pc_d, imm: imm_d, rd1: rd1_d, rd2: rd2_d, rs1: rs1_d, rs2: rs2_d,
                      rd: rd_d, funct3: funct3_d, op: op_d, ctrl: ctrl_d};

    assign accept  = valid_d && ready_d;
    assign consume = vld_q && ready_e;

`ifdef ID_EX_SKID_BUF_EN
    beat_t skid_q, skid_d;
    logic  skid_vld_q, skid_vld_d;
    logic  rdy_q;

    assign ready_d = rdy_q;

    // ready_d low whenever skid is full, so accept never coincides with a skid drain.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        vld_d      = vld_q;
        skid_vld_d = skid_vld_q;
        if (flush_e) begin
            vld_d      = 1'b0;
            skid_vld_d = 1'b0;
        end else if (consume) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d = in_dat;
            end else begin
                vld_d = 1'b0;
            end
        end else if (accept) begin
            if (vld_q) begin
                skid_d     = in_dat;
                skid_vld_d = 1'b1;
            end else begin
                main_d = in_dat;
                vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            vld_q      <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            vld_q      <= vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= !skid_vld_d;
        end
    end
`else
    assign ready_d = !vld_q || ready_e;

    always_comb begin
        main_d = main_q;
        vld_d  = vld_q;
        if (flush_e) begin
            vld_d = 1'b0;
        end else if (accept) begin
            main_d = in_dat;
            vld_d  = 1'b1;
        end else if (consume) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            main_q <= main_d;
            vld_q  <= vld_d;
        end
    end
`endif

    assign valid_e   = vld_q;
    assign pc_e      = main_q.pc;
    assign imm_e     = main_q.imm;
    assign rd1_e     = main_q.rd1;
    assign rd2_e     = main_q.rd2;
    assign rs1_e     = main_q.rs1;
    assign rs2_e     = main_q.rs2;
    assign rd_e      = main_q.rd;
    assign funct3_e  = main_q.funct3;
    assign op_e      = vld_q ? main_q.op   : '0;
    assign ctrl_e    = vld_q ? main_q.ctrl : '0;
    assign pcplus4_e = main_q.pc + {{(XLEN-3){1'b0}}, 3'd4};

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (main_q.funct3)
            3'b000:  br_taken = zero_e;
            3'b001:  br_taken = !zero_e;
            3'b100:  br_taken = lt_e;
            3'b101:  br_taken = !lt_e;
            3'b110:  br_taken = ltu_e;
            3'b111:  br_taken = !ltu_e;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pcsrc_e = 2'b00;
        if (vld_q) begin
            if (main_q.op == OP_JAL) begin
                pcsrc_e = 2'b01;
            end else if (main_q.op == OP_JALR) begin
                pcsrc_e = 2'b10;
            end else if (main_q.op == OP_BR && br_taken) begin
                pcsrc_e = 2'b01;
            end
        end
    end

endmodule
